alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
REQ-004 in_valid  input  1  operation presented on a, b, ctl this cycle.
REQ-005 in_ready  output  1  block accepts the operation this cycle; transfer = in_valid && in_ready.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 ctl  input  4  opcode, opcode_e encoding.
REQ-009 out_valid  output  1  result fields valid this cycle.
REQ-010 out_ready  input  1  consumer takes result; transfer = out_valid && out_ready.
REQ-011 alu  output  WIDTH  result.
REQ-012 carry  output  1  carry/borrow of this operation; equals carry-flag value after it.
REQ-013 zero  output  1  high iff alu is all zeros.
REQ-014 err  output  1  high iff ctl was an illegal opcode (14, 15).

Function
REQ-015 Encoding: SEL=0, INC=1, DEC=2, ADD=3, ADD_c=4, SUB=5, SUB_b=6, AND=7, OR=8, XOR=9, SHIFT_L=10, SHIFT_R=11, ROTATE_L=12, ROTATE_R=13.
REQ-016 Pipeline: stage S1 registers a, b, ctl on input transfer; S1->S2 transfer computes the result and registers alu/carry/zero/err; out_* driven by S2.
REQ-017 Latency: result at outputs 2 cycles after input transfer when out_ready stays high; throughput one op per cycle.
REQ-018 in_ready = !S1.valid || S1 advances this cycle; S1 advances when !S2.valid || out_ready.
REQ-019 Backpressure: out_ready low holds S2 contents and out_* stable; S1 holds; in_ready falls once S1 occupied; no op lost or duplicated.
REQ-020 Internal carry flag cf feeds ADD_c (a+b+cf) and SUB_b (a-b-cf); cf updated at the same edge the op enters S2, so back-to-back ops see the prior op's carry.
REQ-021 Arithmetic in WIDTH+1 bits: SEL=b, INC=b+1, DEC=b-1, ADD=a+b; carry = bit WIDTH; for DEC, SUB, SUB_b carry = borrow (1 when true result negative).
REQ-022 AND/OR/XOR/SEL: carry=0, cf cleared.
REQ-023 SHIFT_L: alu={a[W-2:0],0}, carry=a[W-1]; SHIFT_R: alu={0,a[W-1:1]}, carry=a[0].
REQ-024 ROTATE_L: alu={a[W-2:0],cf}, carry=a[W-1]; ROTATE_R: alu={cf,a[W-1:1]}, carry=a[0] (rotate through carry).
REQ-025 Illegal opcode: op still flows through pipeline, alu=0, carry=cf (unchanged), zero=1, err=1; cf not modified.
REQ-026 Wrap-around: INC of all-ones gives 0, carry=1, zero=1; DEC of 0 gives all-ones, carry=1.
REQ-027 Output fields S2 registers only; no combinational path from a/b/ctl to outputs.

Reset
REQ-028 Reset assertion: S1.valid=0, S2.valid=0, out_valid=0, alu=0, carry=0, zero=0, err=0, cf=0, asynchronously.
REQ-029 Reset mid-operation discards all in-flight ops; in_ready=1 on first edge after release.
REQ-030 Data registers of S1 need no reset; only valid bits and output/flag registers.

Structure
REQ-031 opcode_e typedef (4-bit enum) and the illegal-opcode threshold constant in shared package alu_pkg.
REQ-032 Combinational datapath in sub-module alu_core (WIDTH param; inputs a, b, ctl, cf; outputs result, carry, err); alu_pipe holds handshake, pipeline registers, cf.

Verification
REQ-033 WIDTH=8, ADD a=0xF0 b=0x20, then ADD_c a=0x01 b=0x01 back-to-back -> alu=0x10 carry=1, then alu=0x03 carry=0.
REQ-034 SUB a=0x05 b=0x06 -> alu=0xFF carry=1 zero=0; following SUB_b a=0x10 b=0x00 -> alu=0x0F carry=0.
REQ-035 out_ready low for 4 cycles while streaming 3 ops -> outputs frozen, in_ready low after S1 fills, all 3 results delivered in order once released.
REQ-036 ctl=14 a=0x33 b=0x44 with cf=1 -> alu=0x00 err=1 zero=1 carry=1; subsequent ADD_c 0x00+0x00 -> alu=0x01.
REQ-037 ROTATE_L a=0x81 with cf=0 -> alu=0x02 carry=1; next ROTATE_R a=0x02 -> alu=0x81 carry=0.
REQ-038 Reset pulse with both stages full -> out_valid=0, cf=0 immediately; after release INC b=0xFF -> alu=0x00 carry=1 zero=1 at latency 2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and shared constants for the pipelined ALU.
// Imported by alu_core and alu_pipe.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SEL   = 4'd0,
    OP_INC   = 4'd1,
    OP_DEC   = 4'd2,
    OP_ADD   = 4'd3,
    OP_ADD_C = 4'd4,
    OP_SUB   = 4'd5,
    OP_SUB_B = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_ROL   = 4'd12,
    OP_ROR   = 4'd13
  } opcode_e;

  // Opcodes at or above this value are illegal.
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd14;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath (a, b, ctl, cf in; result, carry, err out).
// carry is also the next carry-flag value; illegal opcodes pass cf through.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctl,
  input  logic             cf,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err
);

  logic [WIDTH:0] ax;
  logic [WIDTH:0] bx;
  logic [WIDTH:0] cx;
  logic [WIDTH:0] one;
  logic [WIDTH:0] sum;

  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = {{WIDTH{1'b0}}, cf};
  assign one = {{WIDTH{1'b0}}, 1'b1};

  // Subtractions in WIDTH+1 bits leave the borrow in the top bit.
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    unique case (ctl)
      OP_SEL: begin
        result = b;
      end
      OP_INC: begin
        sum    = bx + one;
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_DEC: begin
        sum    = bx - one;
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_ADD: begin
        sum    = ax + bx;
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_ADD_C: begin
        sum    = ax + bx + cx;
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        sum    = ax - bx;
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB_B: begin
        sum    = ax - bx - cx;
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_AND: begin
        result = a & b;
      end
      OP_OR: begin
        result = a | b;
      end
      OP_XOR: begin
        result = a ^ b;
      end
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_ROL: begin
        result = {a[WIDTH-2:0], cf};
        carry  = a[WIDTH-1];
      end
      OP_ROR: begin
        result = {cf, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: begin
        // Illegal: zero result, flag preserved.
        result = '0;
        carry  = cf;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with internal carry flag.
// Ports: clk, reset (async low), in_valid/in_ready/a/b/ctl, out_valid/out_ready/alu/carry/zero/err.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_ctl;

  logic             s2_valid;
  logic [WIDTH-1:0] alu_q;
  logic             carry_q;
  logic             zero_q;
  logic             err_q;
  logic             cf_q;

  logic             s2_free;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_err;

  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .ctl    (s1_ctl),
    .cf     (cf_q),
    .result (core_res),
    .carry  (core_carry),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Operand registers carry no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_ctl <= ctl;
    end
  end

  // cf moves with the op entering S2, so the next op in S1 sees it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      alu_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      cf_q     <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        alu_q   <= core_res;
        carry_q <= core_carry;
        zero_q  <= (core_res == '0);
        err_q   <= core_err;
        cf_q    <= core_carry;
      end
    end
  end

  assign out_valid = s2_valid;
  assign alu       = alu_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against a behavioural model.
// Scoreboard queue holds expected results in acceptance order.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ctl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu;
  logic         carry;
  logic         zero;
  logic         err;

  always #5 clk = ~clk;

  alu_pipe #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctl       (ctl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu       (alu),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [10:0] exp_q[$];
  int          acc_cyc_q[$];
  logic [7:0]  log_alu[$];
  logic        log_c[$];
  logic        log_z[$];
  logic        log_e[$];
  int          log_lat[$];
  logic        m_cf;

  logic        s_ir;
  logic        s_ov;
  logic [7:0]  s_alu;
  logic        s_c;
  logic        s_z;
  logic        s_e;

  // Returns {err, carry, alu} from the opcode rules using integer arithmetic.
  function automatic logic [9:0] model(int op, int av, int bv, logic cfi);
    int r;
    int c;
    int e;
    int ci;
    ci = int'(cfi);
    r = 0;
    c = 0;
    e = 0;
    case (op)
      0:  r = bv;
      1:  begin r = bv + 1; c = (r > 255) ? 1 : 0; end
      2:  begin r = bv - 1; c = (bv == 0) ? 1 : 0; end
      3:  begin r = av + bv; c = (r > 255) ? 1 : 0; end
      4:  begin r = av + bv + ci; c = (r > 255) ? 1 : 0; end
      5:  begin r = av - bv; c = (r < 0) ? 1 : 0; end
      6:  begin r = av - bv - ci; c = (r < 0) ? 1 : 0; end
      7:  r = av & bv;
      8:  r = av | bv;
      9:  r = av ^ bv;
      10: begin r = av * 2; c = av / 128; end
      11: begin r = av / 2; c = av % 2; end
      12: begin r = av * 2 + ci; c = av / 128; end
      13: begin r = av / 2 + ci * 128; c = av % 2; end
      default: begin r = 0; c = ci; e = 1; end
    endcase
    r = r & 255;
    return {e[0], c[0], r[7:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, score, advance.
  task automatic cycle(input logic v, input int op, input int av,
                       input int bv, input logic ordy, output logic acc);
    logic [9:0]  m;
    logic [10:0] e;
    in_valid  = v;
    ctl       = op[3:0];
    a         = av[7:0];
    b         = bv[7:0];
    out_ready = ordy;
    #1;
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_alu = alu;
    s_c   = carry;
    s_z   = zero;
    s_e   = err;
    acc   = v && in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {21'd0, err, carry, zero, alu}, {21'd0, e});
        log_alu.push_back(alu);
        log_c.push_back(carry);
        log_z.push_back(zero);
        log_e.push_back(err);
        log_lat.push_back(cyc - acc_cyc_q.pop_front());
      end
    end
    if (acc) begin
      m    = model(op, av, bv, m_cf);
      m_cf = m[8];
      exp_q.push_back({m[9], m[8], (m[7:0] == 8'd0), m[7:0]});
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int op, input int av, input int bv, input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    do begin
      cycle(1'b1, op, av, bv, ordy, acc);
      n++;
    end while (!acc && n < 50);
    chk("send_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle(1'b0, 0, 0, 0, 1'b1, acc);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int   base;
    int   idx;
    int   n;
    logic acc;
    logic [7:0] snap_alu;
    logic snap_c;
    logic snap_z;
    logic snap_e;
    int   bp_op[3];
    int   bp_a[3];
    int   bp_b[3];

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    ctl       = '0;
    m_cf      = 1'b0;
    snap_alu  = '0;
    snap_c    = 1'b0;
    snap_z    = 1'b0;
    snap_e    = 1'b0;

    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", {24'd0, alu}, 32'd0);
    chk("rst_flags", {29'd0, carry, zero, err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Carry chain into ADD_c, back to back.
    base = log_alu.size();
    send(3, 8'hF0, 8'h20, 1'b1);
    send(4, 8'h01, 8'h01, 1'b1);
    drain();
    chk("add_alu", {24'd0, log_alu[base]}, 32'h10);
    chk("add_c", {31'd0, log_c[base]}, 32'd1);
    chk("addc_alu", {24'd0, log_alu[base+1]}, 32'h03);
    chk("addc_c", {31'd0, log_c[base+1]}, 32'd0);
    chk("lat_first", log_lat[base], 2);
    chk("lat_b2b", log_lat[base+1], 2);

    // Borrow into SUB_b.
    base = log_alu.size();
    send(5, 8'h05, 8'h06, 1'b1);
    send(6, 8'h10, 8'h00, 1'b1);
    drain();
    chk("sub_alu", {24'd0, log_alu[base]}, 32'hFF);
    chk("sub_c", {31'd0, log_c[base]}, 32'd1);
    chk("sub_z", {31'd0, log_z[base]}, 32'd0);
    chk("subb_alu", {24'd0, log_alu[base+1]}, 32'h0F);
    chk("subb_c", {31'd0, log_c[base+1]}, 32'd0);

    // Illegal opcode preserves cf.
    base = log_alu.size();
    send(3, 8'hFF, 8'h01, 1'b1);
    send(14, 8'h33, 8'h44, 1'b1);
    send(4, 8'h00, 8'h00, 1'b1);
    drain();
    chk("ill_alu", {24'd0, log_alu[base+1]}, 32'h00);
    chk("ill_flags", {29'd0, log_e[base+1], log_z[base+1], log_c[base+1]}, 32'd7);
    chk("ill_addc", {24'd0, log_alu[base+2]}, 32'h01);

    // Rotates through carry.
    base = log_alu.size();
    send(7, 8'h00, 8'h00, 1'b1);
    send(12, 8'h81, 8'h00, 1'b1);
    send(13, 8'h02, 8'h00, 1'b1);
    drain();
    chk("rol_alu", {24'd0, log_alu[base+1]}, 32'h02);
    chk("rol_c", {31'd0, log_c[base+1]}, 32'd1);
    chk("ror_alu", {24'd0, log_alu[base+2]}, 32'h81);
    chk("ror_c", {31'd0, log_c[base+2]}, 32'd0);

    // Backpressure: four cycles of out_ready low while streaming 3 ops.
    bp_op = '{3, 9, 1};
    bp_a  = '{1, 8'h55, 0};
    bp_b  = '{2, 8'hFF, 7};
    base  = log_alu.size();
    idx   = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(idx < 3, bp_op[idx % 3], bp_a[idx % 3], bp_b[idx % 3], 1'b0, acc);
      if (acc) idx++;
      if (k >= 2) begin
        chk("bp_in_ready", {31'd0, s_ir}, 32'd0);
        chk("bp_out_valid", {31'd0, s_ov}, 32'd1);
      end
      if (k == 2) begin
        snap_alu = s_alu;
        snap_c   = s_c;
        snap_z   = s_z;
        snap_e   = s_e;
      end
      if (k == 3) begin
        chk("bp_stable", {21'd0, s_e, s_c, s_z, s_alu},
            {21'd0, snap_e, snap_c, snap_z, snap_alu});
      end
    end
    chk("bp_accepted", idx, 2);
    n = 0;
    while (idx < 3 && n < 20) begin
      cycle(1'b1, bp_op[idx], bp_a[idx], bp_b[idx], 1'b1, acc);
      if (acc) idx++;
      n++;
    end
    drain();
    chk("bp_order0", {24'd0, log_alu[base]}, 32'h03);
    chk("bp_order1", {24'd0, log_alu[base+1]}, 32'hAA);
    chk("bp_order2", {24'd0, log_alu[base+2]}, 32'h08);

    // Reset with both stages full.
    send(3, 8'hFF, 8'h01, 1'b0);
    send(3, 8'h01, 8'h01, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_cf", {31'd0, dut.cf_q}, 32'd0);
    chk("mrst_fields", {21'd0, err, carry, zero, alu}, 32'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    m_cf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    base = log_alu.size();
    send(1, 8'h00, 8'hFF, 1'b1);
    drain();
    chk("inc_wrap", {21'd0, log_e[base], log_c[base], log_z[base], log_alu[base]},
        {21'd0, 1'b0, 1'b1, 1'b1, 8'h00});
    chk("inc_lat", log_lat[base], 2);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
